// File: rtl/s1423_pkg.sv
// Shared types and helpers for the s1423 compare scheduler and its datapath.
// rr_pick is sized for the largest supported requester count (8).
package s1423_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 5;
    localparam int ID_W_DEF  = 2;
    localparam int MAX_REQ   = 8;

    // One-hot round-robin winner: first set bit of valid at or above ptr,
    // wrapping modulo n. Returns zero when nothing is valid.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int                 idx;
        logic [2:0]         sel;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            sel = idx[2:0];
            if (k < n && !found && valid[sel]) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/s1423_mag_cmp.sv
// Combinational unsigned magnitude compare, MSB-first ripple of per-bit
// greater-than and equality terms (same shape as the XOR/AOI cone chain).
module s1423_mag_cmp #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ge,
    output logic             eq
);

    logic gt_c;
    logic eq_c;

    always_comb begin
        gt_c = 1'b0;
        eq_c = 1'b1;
        // A higher bit decides only while every bit above it is equal.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            gt_c = gt_c | (eq_c & a[i] & ~b[i]);
            eq_c = eq_c & ~(a[i] ^ b[i]);
        end
    end

    assign ge = gt_c | eq_c;
    assign eq = eq_c;

endmodule

// File: rtl/s1423_cmp_sched.sv
// Round-robin scheduler sharing one magnitude comparator among N_REQ
// requesters; results return on a single valid/ready channel tagged by ID.
module s1423_cmp_sched
    import s1423_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = WIDTH_DEF,
    parameter int ID_W  = ID_W_DEF,
    parameter int CNT_W = 8
) (
    input  logic                   CK,
    input  logic                   RN,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_inv,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_ge,
    output logic                   rsp_eq,
    output logic                   busy,
    output logic [CNT_W-1:0]       cmp_count
);

    state_t            state;
    state_t            state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [N_REQ-1:0]  grant;
    logic              can_accept;
    logic              accept;
    logic              handoff;

    logic [ID_W-1:0]   win_id;
    logic [WIDTH-1:0]  win_a;
    logic [WIDTH-1:0]  win_b;
    logic              win_inv;
    logic [ID_W-1:0]   rr_next;

    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              inv_reg;
    logic [ID_W-1:0]   id_reg;

    logic              cmp_ge;
    logic              cmp_eq;

    // Arbitration over the requesters, widened to the helper's fixed size.
    always_comb begin
        logic [MAX_REQ-1:0] valid_ext;
        logic [MAX_REQ-1:0] pick;
        valid_ext              = '0;
        valid_ext[N_REQ-1:0]   = req_valid;
        pick                   = rr_pick(valid_ext, 3'(rr_ptr), N_REQ);
        grant                  = pick[N_REQ-1:0];
    end

    always_comb begin
        win_id  = '0;
        win_a   = '0;
        win_b   = '0;
        win_inv = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win_id  = ID_W'(i);
                win_a   = req_a[i*WIDTH +: WIDTH];
                win_b   = req_b[i*WIDTH +: WIDTH];
                win_inv = req_inv[i];
            end
        end
        rr_next = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
    end

    // A new request can enter while idle, or in the same edge as a handoff.
    assign handoff    = (state == HOLD) && rsp_ready;
    assign can_accept = (state == IDLE) || handoff;
    assign accept     = can_accept && (|grant);
    assign req_ready  = (RN && can_accept) ? grant : '0;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CMP;
            CMP:     state_next = HOLD;
            HOLD: begin
                if (rsp_ready) state_next = accept ? CMP : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) state <= IDLE;
        else     state <= state_next;
    end

    s1423_mag_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a  (a_reg),
        .b  (b_reg),
        .ge (cmp_ge),
        .eq (cmp_eq)
    );

    // Operand capture on accept; result capture during the CMP cycle.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            rr_ptr    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            inv_reg   <= 1'b0;
            id_reg    <= '0;
            rsp_id    <= '0;
            rsp_ge    <= 1'b0;
            rsp_eq    <= 1'b0;
            cmp_count <= '0;
        end else begin
            if (accept) begin
                a_reg   <= win_a;
                b_reg   <= win_b;
                inv_reg <= win_inv;
                id_reg  <= win_id;
                rr_ptr  <= rr_next;
            end
            if (state == CMP) begin
                rsp_id <= id_reg;
                rsp_ge <= inv_reg ? ~cmp_ge : cmp_ge;
                rsp_eq <= cmp_eq;
            end
            if (handoff) cmp_count <= cmp_count + 1'b1;
        end
    end

    assign rsp_valid = (state == HOLD);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_s1423_cmp_sched.sv
// Bench for s1423_cmp_sched: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_s1423_cmp_sched;

    localparam int N   = 4;
    localparam int W   = 5;
    localparam int IDW = 2;
    localparam int CW  = 8;

    logic           CK = 1'b0;
    logic           RN = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0]   req_inv = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [IDW-1:0] rsp_id;
    logic           rsp_ge;
    logic           rsp_eq;
    logic           busy;
    logic [CW-1:0]  cmp_count;

    s1423_cmp_sched #(.N_REQ(N), .WIDTH(W), .ID_W(IDW), .CNT_W(CW)) dut (
        .CK        (CK),
        .RN        (RN),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_inv   (req_inv),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_ge    (rsp_ge),
        .rsp_eq    (rsp_eq),
        .busy      (busy),
        .cmp_count (cmp_count)
    );

    always #5 CK = ~CK;

    int tests = 0;
    int fails = 0;
    int rst_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: at most one compare in flight; it becomes visible one edge after
    // the accepting edge and stays until the consumer takes it.
    int  m_rr = 0, m_pend = 0, m_wait = 0, m_id = 0, m_ge = 0, m_eq = 0, m_count = 0;
    int  seen_pulses = 0;

    always @(negedge CK) begin : model
        logic [N-1:0] exp_ready;
        logic [W-1:0] ma, mb;
        int  w, idx;
        bit  vis, can;
        if (!RN || rst_pulses != seen_pulses) begin
            m_rr = 0; m_pend = 0; m_wait = 0; m_count = 0;
            seen_pulses = rst_pulses;
        end
        if (RN) begin
            vis = (m_pend != 0) && (m_wait == 0);
            can = (m_pend == 0) || (vis && rsp_ready);
            w = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (w < 0 && req_valid[idx]) w = idx;
            end
            exp_ready = '0;
            if (can && w >= 0) exp_ready[w] = 1'b1;
            check("m_req_ready", 32'(req_ready), 32'(exp_ready));
            check("m_rsp_valid", 32'(rsp_valid), 32'(vis));
            check("m_busy", 32'(busy), 32'(m_pend != 0));
            check("m_cmp_count", 32'(cmp_count), 32'(m_count));
            if (vis) begin
                check("m_rsp_id", 32'(rsp_id), 32'(m_id));
                check("m_rsp_ge", 32'(rsp_ge), 32'(m_ge));
                check("m_rsp_eq", 32'(rsp_eq), 32'(m_eq));
            end
            if (vis && rsp_ready) begin
                m_count = (m_count + 1) % 256;
                m_pend  = 0;
            end else if (m_pend != 0 && m_wait > 0) begin
                m_wait--;
            end
            if (exp_ready != '0) begin
                ma = req_a[w*W +: W];
                mb = req_b[w*W +: W];
                m_ge   = req_inv[w] ? int'(ma < mb) : int'(ma >= mb);
                m_eq   = int'(ma == mb);
                m_id   = w;
                m_pend = 1;
                m_wait = 1;
                m_rr   = (w + 1) % N;
            end
        end
    end

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset();
        RN = 1'b0;
        rst_pulses++;
        req_valid = '0;
        step();
        step();
        RN = 1'b1;
    endtask

    task automatic single(input int idx, input int a, input int b, input bit inv,
                          input int exp_ge, input int exp_eq, input int exp_cnt);
        step();
        req_valid = '0;
        req_valid[idx] = 1'b1;
        req_a[idx*W +: W] = W'(a);
        req_b[idx*W +: W] = W'(b);
        req_inv[idx] = inv;
        rsp_ready = 1'b1;
        @(negedge CK);
        check("t_ready", 32'(req_ready), 32'(1) << idx);
        step();
        req_valid = '0;
        @(negedge CK);
        check("t_cmp_valid", 32'(rsp_valid), 0);
        check("t_cmp_busy", 32'(busy), 1);
        step();
        @(negedge CK);
        check("t_rsp_valid", 32'(rsp_valid), 1);
        check("t_rsp_id", 32'(rsp_id), 32'(idx));
        check("t_rsp_ge", 32'(rsp_ge), 32'(exp_ge));
        check("t_rsp_eq", 32'(rsp_eq), 32'(exp_eq));
        step();
        @(negedge CK);
        check("t_count", 32'(cmp_count), 32'(exp_cnt));
        check("t_done_valid", 32'(rsp_valid), 0);
    endtask

    initial begin : stim
        int grants[5];
        int gcyc[5];
        int ng, h, gi;
        bit done;
        logic [N-1:0] acc;

        // Reset values, even with every request asserted.
        req_valid = '1;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(cmp_count), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_ge_eq", 32'({rsp_ge, rsp_eq}), 0);
        req_valid = '0;
        step();
        step();
        RN = 1'b1;

        single(0, 20, 13, 1'b0, 1, 0, 1);
        single(2, 31, 31, 1'b1, 0, 1, 2);
        single(2, 0, 1, 1'b1, 1, 0, 3);

        // Round robin with all requesters continuously valid.
        do_reset();
        req_valid = '1;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'($urandom);
            req_b[i*W +: W] = W'($urandom);
        end
        rsp_ready = 1'b1;
        ng = 0;
        for (int c = 0; c < 14 && ng < 5; c++) begin
            @(negedge CK);
            if (req_ready != '0) begin
                gi = -1;
                for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
                grants[ng] = gi;
                gcyc[ng] = c;
                ng++;
            end
            step();
        end
        check("rr_grants", 32'(ng), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < ng) begin
                check("rr_order", 32'(grants[k]), 32'(k % N));
                if (k > 0) check("rr_gap", 32'(gcyc[k] - gcyc[k-1]), 2);
            end
        end

        // Backpressure: response held while requester 1 waits.
        do_reset();
        req_valid = 4'b0011;
        req_a[0 +: W] = 5'd7;  req_b[0 +: W] = 5'd9;  req_inv[0] = 1'b0;
        req_a[W +: W] = 5'd12; req_b[W +: W] = 5'd3;  req_inv[1] = 1'b0;
        rsp_ready = 1'b0;
        @(negedge CK);
        check("bp_first_ready", 32'(req_ready), 32'(4'b0001));
        step();
        req_valid = 4'b0010;
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge CK);
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_id", 32'(rsp_id), 0);
            check("bp_ge_eq", 32'({rsp_ge, rsp_eq}), 0);
            check("bp_ready", 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge CK);
        check("bp_same_edge_ready", 32'(req_ready), 32'(4'b0010));
        step();
        rsp_ready = 1'b0;
        req_valid = '0;
        @(negedge CK);
        check("bp_count", 32'(cmp_count), 1);
        check("bp_busy", 32'(busy), 1);
        step();
        @(negedge CK);
        check("bp_second_id", 32'(rsp_id), 1);
        check("bp_second_ge", 32'(rsp_ge), 1);

        // Asynchronous reset pulsed between edges while holding a response.
        @(posedge CK);
        #2;
        RN = 1'b0;
        rst_pulses++;
        #1;
        check("arst_valid", 32'(rsp_valid), 0);
        check("arst_count", 32'(cmp_count), 0);
        check("arst_busy", 32'(busy), 0);
        #1;
        RN = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CK);
            check("arst_no_stale", 32'(rsp_valid), 0);
            step();
        end
        req_valid = 4'b1001;
        @(negedge CK);
        check("arst_rr_ptr", 32'(req_ready), 32'(4'b0001));

        // Counter wrap after 256 handoffs.
        step();
        do_reset();
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        h = 0;
        done = 1'b0;
        for (int c = 0; c < 1200 && !done; c++) begin
            @(negedge CK);
            if (h == 255) check("wrap_255", 32'(cmp_count), 255);
            if (h == 256) begin
                check("wrap_zero", 32'(cmp_count), 0);
                done = 1'b1;
            end else begin
                if (rsp_valid) h++;
                step();
            end
        end
        if (!done) check("wrap_timeout", 0, 1);

        // Randomized traffic; requesters hold operands until accepted.
        step();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge CK);
            acc = req_ready & req_valid;
            step();
            if (c == 1500) begin
                #1;
                RN = 1'b0;
                rst_pulses++;
                #2;
                RN = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !acc[i]) begin
                    if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = 1'($urandom_range(1));
                    req_a[i*W +: W] = W'($urandom);
                    req_b[i*W +: W] = ($urandom_range(3) == 0) ? req_a[i*W +: W] : W'($urandom);
                    req_inv[i] = 1'($urandom_range(1));
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
        end

        @(negedge CK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
